// File: rtl/aes_pkg.sv
// Shared AES-128 cipher definitions: round count, controller states, GF(2^8) helpers.
// Latency: n/a (types and combinational functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int         NR         = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as SubBytes needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (bypassed on last), AddRoundKey.
// Latency: combinational.
// Backpressure: n/a.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_out
);

    // FIPS byte k = row + 4*col sits at element 15-k, so element 15 is [127:120].
    logic [15:0][7:0] sub_b;
    logic [15:0][7:0] shf_b;
    logic [15:0][7:0] mix_b;

    genvar i, r, c;

    for (i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .sb_in  (st_in[8*i +: 8]),
            .sb_out (sub_b[i])
        );
    end

    for (r = 0; r < 4; r++) begin : g_row
        for (c = 0; c < 4; c++) begin : g_col
            assign shf_b[15-(r+4*c)] = sub_b[15-(r+4*((c+r)%4))];
        end
    end

    for (c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shf_b[15-4*c];
        assign a1 = shf_b[14-4*c];
        assign a2 = shf_b[13-4*c];
        assign a3 = shf_b[12-4*c];
        assign mix_b[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mix_b[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mix_b[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mix_b[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign st_out = (last ? shf_b : mix_b) ^ rk;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse followed by the affine transform.
// Latency: combinational.
// Backpressure: n/a.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sb_in,
    output logic [7:0] sb_out
);

    logic [7:0] inv;

    assign inv    = gf_inv(sb_in);
    assign sb_out = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_cipher_iter_128.sv
// Iterative AES-128 encryption, one round per clock over a single state register.
// Latency: out_valid rises 10 edges after the accept edge; one block in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready stays low while busy.
module aes_cipher_iter_128
    import aes_pkg::*;
#(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_s0,
    input  logic [127:0] key_s1,
    input  logic [127:0] key_s2,
    input  logic [127:0] key_s3,
    input  logic [127:0] key_s4,
    input  logic [127:0] key_s5,
    input  logic [127:0] key_s6,
    input  logic [127:0] key_s7,
    input  logic [127:0] key_s8,
    input  logic [127:0] key_s9,
    input  logic [127:0] key_s10,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    fsm_state_t   fsm_state;
    fsm_state_t   fsm_next;
    logic [3:0]   round_q;
    logic [127:0] state_q;
    logic [127:0] round_key;
    logic [127:0] round_out;
    logic         last_round;
    logic         accept;
    logic         handoff;

    assign last_round = (round_q == LAST_ROUND);

    // Keys are not latched; the expander holds them static for the whole block.
    always_comb begin
        round_key = key_s0;
        case (round_q)
            4'd1:    round_key = key_s1;
            4'd2:    round_key = key_s2;
            4'd3:    round_key = key_s3;
            4'd4:    round_key = key_s4;
            4'd5:    round_key = key_s5;
            4'd6:    round_key = key_s6;
            4'd7:    round_key = key_s7;
            4'd8:    round_key = key_s8;
            4'd9:    round_key = key_s9;
            4'd10:   round_key = key_s10;
            default: round_key = key_s0;
        endcase
    end

    aes_round_comb u_round (
        .st_in  (state_q),
        .rk     (round_key),
        .last   (last_round),
        .st_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    always_comb begin
        fsm_next  = fsm_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        handoff   = 1'b0;
        case (fsm_state)
            IDLE: begin
                in_ready = rst_n;
                accept   = in_valid & rst_n;
                if (accept) fsm_next = RUN;
            end
            RUN: begin
                if (last_round) fsm_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                handoff   = out_ready;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            round_q <= '0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (accept) begin
                        state_q <= in_data ^ key_s0;
                        round_q <= 4'd1;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    round_q <= last_round ? 4'd0 : round_q + 4'd1;
                end
                DONE: begin
                    if (handoff && CLEAR_ON_DONE) state_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign out_data = state_q;

endmodule
